// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the fetch-sequencing stage.
//   pc_t        : default-width program-counter value (PC_MSB+1 bits)
//   pc_state_e  : sequencer state (IDLE / RUN / DONE)
//   PC_RESET    : address loaded on reset and on start
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_MSB   = 9;
    localparam int PC_RESET = 0;

    typedef logic [PC_MSB:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;

endpackage

// File: rtl/prog_counter_if.sv
// ---------------------------------------------------------------------------
// prog_counter_if
// Control/status bundle between the decoder side and the program counter.
//   Decoder -> PC : start, stall, branch_en, call_en, ret_en, halt, target
//   PC -> decoder : pc, running, done, ras_ovf, ras_unf
// master modport drives the control inputs; slave modport is the PC itself.
// ---------------------------------------------------------------------------
interface prog_counter_if #(
    parameter int D = 9
);
    logic         start;
    logic         stall;
    logic         branch_en;
    logic         call_en;
    logic         ret_en;
    logic         halt;
    logic [D:0]   target;
    logic [D:0]   pc;
    logic         running;
    logic         done;
    logic         ras_ovf;
    logic         ras_unf;

    modport master (
        output start, stall, branch_en, call_en, ret_en, halt, target,
        input  pc, running, done, ras_ovf, ras_unf
    );

    modport slave (
        input  start, stall, branch_en, call_en, ret_en, halt, target,
        output pc, running, done, ras_ovf, ras_unf
    );
endinterface

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Small LIFO holding return addresses.
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   clr        : synchronous pointer clear (used when a new run starts)
//   push, pop  : pop wins if both are asserted; push when full and pop when
//                empty are ignored
//   data_in    : value pushed
//   data_out   : current top entry, combinational read (undefined when empty)
//   full/empty : occupancy flags decoded from the registered pointer
// DEPTH must be a power of two between 2 and 16 so the index wraps cleanly.
// ---------------------------------------------------------------------------
module ras_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Occupancy count, one bit wider than the index so full is distinguishable.
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              wr_en;
    logic [DEPTH-1:0]  we_vec;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr_idx = cnt_q[AW-1:0];
    // Top entry sits one below the count; wraps harmlessly when empty.
    assign rd_idx = wr_idx - AW'(1);
    assign data_out = mem[rd_idx];

    assign wr_en = push && !pop && !full && !clr;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_vec[gi] = wr_en && (wr_idx == AW'(gi));
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (pop) begin
            if (!empty) begin
                cnt_d = cnt_q - (AW+1)'(1);
            end
        end else if (push && !full) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; stale entries are never read while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_vec[i]) begin
                mem[i] <= data_in;
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
// Program counter and fetch sequencer with a return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : begin execution at address 0 (accepted from IDLE/DONE only)
//   bus.stall  : freeze PC, state, stack and flags for this cycle
//   bus.halt / ret_en / call_en / branch_en : next-PC selects, in that priority
//   bus.target : absolute jump/call target
//   bus.pc     : registered instruction address
//   bus.running / done : state decodes
//   bus.ras_ovf / ras_unf : sticky stack overflow / underflow flags
// All outputs come straight from flops; inputs affect pc one clock later.
// ---------------------------------------------------------------------------
module prog_counter
    import cpu_pkg::*;
#(
    parameter int D         = PC_MSB,
    parameter int RAS_DEPTH = 4,
    parameter int PROG_END  = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_counter_if.slave     bus
);
    localparam int         W       = D + 1;
    localparam logic [D:0] PC_END  = W'(PROG_END);
    localparam logic [D:0] PC_ZERO = W'(PC_RESET);

    pc_state_e  state_q, state_d;
    logic [D:0] pc_q, pc_d;
    logic [D:0] pc_inc;
    logic [D:0] ras_top;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       ras_push, ras_pop, ras_clr;
    logic       ras_full, ras_empty;
    logic       take_inc;

    // Wraps modulo 2^(D+1); only visible when PROG_END is below the top address.
    assign pc_inc = pc_q + W'(1);

    ras_stack #(
        .WIDTH (W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ras_clr),
        .push     (ras_push),
        .pop      (ras_pop),
        .data_in  (pc_inc),
        .data_out (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_clr  = 1'b0;
        take_inc = 1'b0;

        case (state_q)
            IDLE: begin
                pc_d = PC_ZERO;
                // start is honoured even when stalled.
                if (bus.start) begin
                    state_d = RUN;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    ras_clr = 1'b1;
                end
            end

            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = DONE;
                    end else if (bus.ret_en) begin
                        // Underflow falls through as a plain increment.
                        if (ras_empty) begin
                            unf_d    = 1'b1;
                            take_inc = 1'b1;
                        end else begin
                            ras_pop = 1'b1;
                            pc_d    = ras_top;
                        end
                    end else if (bus.call_en) begin
                        // Overflow drops the push but still takes the jump.
                        if (ras_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            ras_push = 1'b1;
                        end
                        pc_d = bus.target;
                    end else if (bus.branch_en) begin
                        pc_d = bus.target;
                    end else begin
                        take_inc = 1'b1;
                    end

                    // Sequential fetch past the last instruction ends the run.
                    if (take_inc) begin
                        if (pc_q == PC_END) begin
                            state_d = DONE;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end

            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = PC_ZERO;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    ras_clr = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = PC_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= PC_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;

endmodule

// File: tb/tb_prog_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_counter
// Two instances: dut_a with default sizing, dut_b with D=5 and PROG_END=39
// (exercises end-of-program and pc wrap). Vectors are applied from a table;
// each vector's expected outputs are queued when driven and checked one
// clock later. Status nibble is {running, done, ras_ovf, ras_unf}.
// ---------------------------------------------------------------------------
module tb_prog_counter;
    import cpu_pkg::*;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] S   = 6'b100000;
    localparam logic [5:0] SL  = 6'b010000;
    localparam logic [5:0] BR  = 6'b001000;
    localparam logic [5:0] CL  = 6'b000100;
    localparam logic [5:0] RT  = 6'b000010;
    localparam logic [5:0] HT  = 6'b000001;

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] R  = 4'b1000;
    localparam logic [3:0] DN = 4'b0100;
    localparam logic [3:0] O  = 4'b0010;
    localparam logic [3:0] U  = 4'b0001;

    typedef struct {
        int         dut;
        string      name;
        logic [5:0] ctl;
        logic [9:0] tgt;
        logic [9:0] exp_pc;
        logic [3:0] exp_st;
    } vec_t;

    typedef struct {
        int          dut;
        string       name;
        logic [13:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    prog_counter_if #(.D(9)) bus_a ();
    prog_counter_if #(.D(5)) bus_b ();

    prog_counter #(.D(9), .RAS_DEPTH(4), .PROG_END(1023)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    prog_counter #(.D(5), .RAS_DEPTH(4), .PROG_END(39)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    function automatic vec_t mk(int dut, string name, logic [5:0] ctl,
                                int tgt, int pc, logic [3:0] st);
        vec_t v;
        v.dut    = dut;
        v.name   = name;
        v.ctl    = ctl;
        v.tgt    = 10'(tgt);
        v.exp_pc = 10'(pc);
        v.exp_st = st;
        return v;
    endfunction

    task automatic drive(int dut, logic [5:0] ctl, logic [9:0] tgt);
        logic [5:0] ca;
        logic [5:0] cb;
        ca = (dut == 0) ? ctl : NOP;
        cb = (dut == 1) ? ctl : NOP;
        bus_a.start = ca[5]; bus_a.stall = ca[4]; bus_a.branch_en = ca[3];
        bus_a.call_en = ca[2]; bus_a.ret_en = ca[1]; bus_a.halt = ca[0];
        bus_a.target = tgt;
        bus_b.start = cb[5]; bus_b.stall = cb[4]; bus_b.branch_en = cb[3];
        bus_b.call_en = cb[2]; bus_b.ret_en = cb[1]; bus_b.halt = cb[0];
        bus_b.target = tgt[5:0];
    endtask

    task automatic expect_push(int dut, string name, logic [9:0] pc, logic [3:0] st);
        exp_t e;
        e.dut  = dut;
        e.name = name;
        e.exp  = {pc, st};
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t        e;
        logic [13:0] act;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = sb.pop_front();
            if (e.dut == 0)
                act = {bus_a.pc, bus_a.running, bus_a.done, bus_a.ras_ovf, bus_a.ras_unf};
            else
                act = {4'b0000, bus_b.pc, bus_b.running, bus_b.done, bus_b.ras_ovf, bus_b.ras_unf};
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got pc=%0d st=%b, expected pc=%0d st=%b",
                         e.name, act[13:4], act[3:0], e.exp[13:4], e.exp[3:0]);
            end else begin
                $display("[TB] ok %s: pc=%0d st=%b", e.name, act[13:4], act[3:0]);
            end
        end
    endtask

    task automatic apply(vec_t v);
        drive(v.dut, v.ctl, v.tgt);
        expect_push(v.dut, v.name, v.exp_pc, v.exp_st);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // dut_b: end of program at 39 and wrap from 63 to 0.
        vecs.push_back(mk(1, "b_start",      S,   0,  0, R));
        vecs.push_back(mk(1, "b_br37",       BR, 37, 37, R));
        vecs.push_back(mk(1, "b_inc38",      NOP, 0, 38, R));
        vecs.push_back(mk(1, "b_inc39",      NOP, 0, 39, R));
        vecs.push_back(mk(1, "b_end_done",   NOP, 0, 39, DN));
        vecs.push_back(mk(1, "b_done_hold",  NOP, 0, 39, DN));
        vecs.push_back(mk(1, "b_restart",    S,   0,  0, R));
        vecs.push_back(mk(1, "b_br63",       BR, 63, 63, R));
        vecs.push_back(mk(1, "b_wrap0",      NOP, 0,  0, R));
        vecs.push_back(mk(1, "b_inc1",       NOP, 0,  1, R));
        // dut_a: sequential, branch, call/return.
        vecs.push_back(mk(0, "a_start",      S,    0,   0, R));
        vecs.push_back(mk(0, "a_inc1",       NOP,  0,   1, R));
        vecs.push_back(mk(0, "a_inc2",       NOP,  0,   2, R));
        vecs.push_back(mk(0, "a_inc3",       NOP,  0,   3, R));
        vecs.push_back(mk(0, "a_br145",      BR, 145, 145, R));
        vecs.push_back(mk(0, "a_inc146",     NOP,  0, 146, R));
        vecs.push_back(mk(0, "a_br10",       BR,  10,  10, R));
        vecs.push_back(mk(0, "a_call210",    CL, 210, 210, R));
        vecs.push_back(mk(0, "a_inc211",     NOP,  0, 211, R));
        vecs.push_back(mk(0, "a_inc212",     NOP,  0, 212, R));
        vecs.push_back(mk(0, "a_inc213",     NOP,  0, 213, R));
        vecs.push_back(mk(0, "a_ret11",      RT,   0,  11, R));
        // Stall dominates branch and call.
        vecs.push_back(mk(0, "a_stall_br",   SL|BR, 300, 11, R));
        vecs.push_back(mk(0, "a_stall_call", SL|CL, 400, 11, R));
        // Underflow: fall through with sticky flag.
        vecs.push_back(mk(0, "a_br20",       BR,  20,  20, R));
        vecs.push_back(mk(0, "a_ret_unf",    RT,   0,  21, R|U));
        // Five nested calls into a four-entry stack.
        vecs.push_back(mk(0, "a_call100",    CL, 100, 100, R|U));
        vecs.push_back(mk(0, "a_call200",    CL, 200, 200, R|U));
        vecs.push_back(mk(0, "a_call300",    CL, 300, 300, R|U));
        vecs.push_back(mk(0, "a_call400",    CL, 400, 400, R|U));
        vecs.push_back(mk(0, "a_call500_ovf",CL, 500, 500, R|O|U));
        vecs.push_back(mk(0, "a_ret301",     RT,   0, 301, R|O|U));
        vecs.push_back(mk(0, "a_ret201",     RT,   0, 201, R|O|U));
        vecs.push_back(mk(0, "a_ret101",     RT,   0, 101, R|O|U));
        vecs.push_back(mk(0, "a_ret22",      RT,   0,  22, R|O|U));
        vecs.push_back(mk(0, "a_ret_empty",  RT,   0,  23, R|O|U));
        // Return beats call in the same cycle; no push happens.
        vecs.push_back(mk(0, "a_call_ret",   CL|RT, 600, 24, R|O|U));
        vecs.push_back(mk(0, "a_call30",     CL,  30,  30, R|O|U));
        // Halt outranks return and branch.
        vecs.push_back(mk(0, "a_halt_prio",  HT|RT|BR, 700, 30, DN|O|U));
        vecs.push_back(mk(0, "a_done_hold",  NOP,  0,  30, DN|O|U));
        vecs.push_back(mk(0, "a_done_br",    BR,   5,  30, DN|O|U));
        // Start under stall from DONE clears flags and the stack pointer.
        vecs.push_back(mk(0, "a_stall_start",S|SL, 0,   0, R));
        vecs.push_back(mk(0, "a_ret_cleared",RT,   0,   1, R|U));
        vecs.push_back(mk(0, "a_start_in_run",S,   0,   2, R|U));
        // Branch taken at PROG_END is followed; increment at PROG_END ends run.
        vecs.push_back(mk(0, "a_br1023",     BR, 1023, 1023, R|U));
        vecs.push_back(mk(0, "a_br_at_end",  BR,   5,    5, R|U));
        vecs.push_back(mk(0, "a_br1023b",    BR, 1023, 1023, R|U));
        vecs.push_back(mk(0, "a_stall_end",  SL,   0, 1023, R|U));
        vecs.push_back(mk(0, "a_end_done",   NOP,  0, 1023, DN|U));
        vecs.push_back(mk(0, "a_end_hold",   NOP,  0, 1023, DN|U));
        vecs.push_back(mk(0, "a_restart",    S,    0,    0, R));
        vecs.push_back(mk(0, "a_stall_halt", SL|HT, 0,   0, R));
        vecs.push_back(mk(0, "a_halt0",      HT,   0,    0, DN));
        vecs.push_back(mk(0, "a_restart2",   S,    0,    0, R));
        vecs.push_back(mk(0, "a_ret_unf2",   RT,   0,    1, R|U));
        vecs.push_back(mk(0, "a_br100",      BR, 100,  100, R|U));

        drive(0, NOP, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        expect_push(0, "a_reset", 10'd0, Z);
        check_front();
        expect_push(1, "b_reset", 10'd0, Z);
        check_front();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset mid-run at pc=100: takes effect without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        expect_push(0, "a_async_rst", 10'd0, Z);
        check_front();
        @(posedge clk);
        #1;
        expect_push(0, "a_rst_held", 10'd0, Z);
        check_front();
        rst_n = 1'b1;
        apply(mk(0, "a_post_rst_start", S,   0, 0, R));
        apply(mk(0, "a_post_rst_inc",   NOP, 0, 1, R));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Program-counter and fetch-sequencing stage for the processor.
- Consumes the absolute branch target produced by the branch-target lookup table.
- Drives the instruction-memory address and reports run/done status to the top level.
- Adds a small return-address stack so that call and return use the same absolute-target path.

Parameters:
- D, 9: MSB index of the PC. PC width is D+1 bits, matching the lookup-table target width.
- RAS_DEPTH, 4: number of return-address stack entries. Must be a power of two, 2 to 16.
- PROG_END, 1023: address of the last instruction. Incrementing past it ends the run.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins execution from address 0.
- stall  input  1  holds the PC and all state this cycle.
- branch_en  input  1  take an absolute jump to target.
- call_en  input  1  push pc+1, then jump to target.
- ret_en  input  1  pop the return-address stack and jump to the popped address.
- halt  input  1  decoded halt instruction.
- target  input  D+1  absolute target from the branch-target lookup table.
- pc  output  D+1  current instruction address.
- running  output  1  high while in RUN.
- done  output  1  high in DONE and held until the next start.
- ras_ovf  output  1  sticky flag: push attempted while the stack was full.
- ras_unf  output  1  sticky flag: pop attempted while the stack was empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=0, state=IDLE, running=0, done=0, ras_ovf=0, ras_unf=0.
  - Stack pointer=0; stack contents don't-care.
- States: IDLE, RUN, DONE.
  - IDLE: pc holds 0. start -> RUN, pc stays 0.
  - RUN: pc updates every cycle not stalled, as below.
  - DONE: pc frozen at the halting address. start -> RUN with pc=0 and flags cleared. The stack pointer is also cleared on start.
- Next-PC priority in RUN, evaluated only when stall=0:
  1. halt: go to DONE, pc unchanged.
  2. ret_en: pc = top of stack, pointer decrements.
  3. call_en: push pc+1, pc = target.
  4. branch_en: pc = target.
  5. Otherwise pc = pc+1.
- End of program:
  - When pc == PROG_END and the next-PC choice is the increment, go to DONE and hold pc.
  - A branch, call or return taken at PROG_END is followed normally.
- Width rules:
  - pc+1 is computed modulo 2^(D+1), so 1023+1 gives 0 with the default D.
  - This wrap only takes effect when PROG_END < 2^(D+1)-1.
  - target is used unmodified (absolute addressing, no offset add).
- Stack:
  - Push when full: no write, pointer unchanged, ras_ovf set. The jump to target still happens.
  - Pop when empty: pc = pc+1 (treated as a no-op fall-through), ras_unf set.
  - call_en and ret_en in the same cycle: ret wins and the call is ignored (no push).
- Stall:
  - Freezes pc, state, stack and flags. stall has priority over everything except reset.
  - start while stalled in IDLE or DONE is still accepted.
- start while in RUN is ignored.
- Latency: all pc changes appear one clock after the qualifying inputs are sampled. No combinational path from inputs to pc.
- Outputs are registered. running and done are decoded from state only.
- Reset asserted mid-run returns immediately to IDLE with pc=0.

Decomposition:
- Shared package cpu_pkg:
  - typedef pc_t, logic [D:0].
  - Enum pc_state_e {IDLE, RUN, DONE}.
  - Constant PC_RESET = 0.
- One sub-module: ras_stack.
  - Parameterized LIFO with push, pop, data_in, data_out, full, empty.
  - Asynchronous active-low reset.
  - Registered pointer; combinational read of the top entry.
- The next-PC mux and state machine stay in prog_counter.

Test Plan:
- Sequential run: reset, pulse start, 5 idle cycles -> pc sequence 0,1,2,3,4,5; running=1, done=0.
- Branch: at pc=3 assert branch_en with target=145 -> next pc=145, then 146.
- Call and return: at pc=10, call_en with target=210 -> pc=210. Three increments reach 213; ret_en -> pc=11.
- Stack boundaries:
  - Five nested calls with RAS_DEPTH=4 -> fifth call still jumps and ras_ovf=1.
  - ret_en with the stack empty at pc=20 -> pc=21 and ras_unf=1.
- Stall and priority:
  - stall=1 with branch_en at pc=6 -> pc holds 6.
  - halt+ret_en+branch_en together at pc=24 -> DONE, pc=24, done=1.
  - start afterwards -> pc=0, done=0.
- End of program and reset:
  - PROG_END=39: reach pc=39 with no branch -> DONE at pc=39.
  - Assert rst_n=0 mid-run at pc=100 -> immediately pc=0, IDLE, flags cleared.
